// File: rtl/multi_key_debouncer_if.sv
//==============================================================================
// Module      : multi_key_debouncer_if
// Description : Key bus between raw key pins and the debounced key outputs.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface multi_key_debouncer_if #(
    parameter int N_KEYS = 3,
    parameter int KEY_W  = 2
);
    logic [N_KEYS-1:0] key_raw;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [KEY_W-1:0]  key_code;
    logic              key_valid;
    logic              any_pressed;

    // Master drives the raw pins and consumes the debounced results.
    modport master (
        output key_raw,
        input  key_level, key_press, key_release, key_code, key_valid, any_pressed
    );

    modport slave (
        input  key_raw,
        output key_level, key_press, key_release, key_code, key_valid, any_pressed
    );
endinterface

`default_nettype wire

// File: rtl/multi_key_debouncer.sv
//==============================================================================
// Module      : multi_key_debouncer
// Description : N-channel key synchroniser/debouncer with press/release pulses,
//               optional auto-repeat and lowest-index press encoder.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module multi_key_debouncer #(
    parameter int N_KEYS        = 3,
    parameter int KEY_W         = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 20,
    parameter int ACTIVE_HIGH   = 1,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_DELAY  = 8,
    parameter int REPEAT_RATE   = 3
) (
    input wire                    sys_clk,
    input wire                    sys_rst_n,
    multi_key_debouncer_if.slave  bus
);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        HELD         = 2'd2,
        RELEASE_PEND = 2'd3
    } state_t;

    localparam logic [N_KEYS-1:0] c_pol_mask    = (ACTIVE_HIGH != 0) ? '0 : '1;
    localparam logic [CNT_W-1:0]  c_stable_last = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_delay_last  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0]  c_rate_last   = CNT_W'(REPEAT_RATE - 1);

    logic [N_KEYS-1:0] sync1_q;
    logic [N_KEYS-1:0] sync2_q;
    logic [N_KEYS-1:0] level_d;
    logic [N_KEYS-1:0] press_d;
    logic [N_KEYS-1:0] release_d;
    logic [N_KEYS-1:0] level_q;
    logic [N_KEYS-1:0] press_q;
    logic [N_KEYS-1:0] release_q;
    logic [KEY_W-1:0]  key_code_d;
    logic [KEY_W-1:0]  key_code_q;
    logic              key_valid_d;
    logic              key_valid_q;
    logic              any_pressed_d;
    logic              any_pressed_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.key_raw ^ c_pol_mask;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] rpt_q, rpt_d;
        logic             rpt_phase_q, rpt_phase_d;
        logic             rpt_fire;
        logic             s;

        assign s = sync2_q[g];

        always_comb begin
            state_d     = state_q;
            cnt_d       = cnt_q;
            rpt_d       = rpt_q;
            rpt_phase_d = rpt_phase_q;
            rpt_fire    = 1'b0;

            case (state_q)
                RELEASED: begin
                    if (s) state_d = PRESS_PEND;
                end
                PRESS_PEND: begin
                    if (!s)                         state_d = RELEASED;
                    else if (cnt_q == c_stable_last) state_d = HELD;
                    else                            cnt_d   = cnt_q + 1'b1;
                end
                HELD: begin
                    if (!s) state_d = RELEASE_PEND;
                end
                RELEASE_PEND: begin
                    if (s)                          state_d = HELD;
                    else if (cnt_q == c_stable_last) state_d = RELEASED;
                    else                            cnt_d   = cnt_q + 1'b1;
                end
                default: state_d = RELEASED;
            endcase

            if (state_d != state_q) cnt_d = '0;

            // Repeat timer only advances while staying in HELD; it is frozen in
            // RELEASE_PEND and cleared once the key leaves the held pair of states.
            if (state_d == RELEASED || state_d == PRESS_PEND) begin
                rpt_d       = '0;
                rpt_phase_d = 1'b0;
            end else if (REPEAT_EN != 0 && state_q == HELD && state_d == HELD) begin
                if (rpt_q == (rpt_phase_q ? c_rate_last : c_delay_last)) begin
                    rpt_fire    = 1'b1;
                    rpt_d       = '0;
                    rpt_phase_d = 1'b1;
                end else begin
                    rpt_d = rpt_q + 1'b1;
                end
            end
        end

        assign level_d[g]   = (state_d == HELD) || (state_d == RELEASE_PEND);
        assign press_d[g]   = ((state_q == PRESS_PEND) && (state_d == HELD)) || rpt_fire;
        assign release_d[g] = (state_q == RELEASE_PEND) && (state_d == RELEASED);

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                state_q     <= RELEASED;
                cnt_q       <= '0;
                rpt_q       <= '0;
                rpt_phase_q <= 1'b0;
            end else begin
                state_q     <= state_d;
                cnt_q       <= cnt_d;
                rpt_q       <= rpt_d;
                rpt_phase_q <= rpt_phase_d;
            end
        end
    end

    // Lowest set index wins; the code holds its last value between strobes.
    always_comb begin
        key_code_d = key_code_q;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (press_d[i]) key_code_d = KEY_W'(i);
        end
    end

    assign key_valid_d   = |press_d;
    assign any_pressed_d = |level_d;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            level_q       <= '0;
            press_q       <= '0;
            release_q     <= '0;
            key_code_q    <= '0;
            key_valid_q   <= 1'b0;
            any_pressed_q <= 1'b0;
        end else begin
            level_q       <= level_d;
            press_q       <= press_d;
            release_q     <= release_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            any_pressed_q <= any_pressed_d;
        end
    end

    assign bus.key_level   = level_q;
    assign bus.key_press   = press_q;
    assign bus.key_release = release_q;
    assign bus.key_code    = key_code_q;
    assign bus.key_valid   = key_valid_q;
    assign bus.any_pressed = any_pressed_q;

endmodule

`default_nettype wire

// File: tb/tb_multi_key_debouncer.sv
//==============================================================================
// Module      : tb_multi_key_debouncer
// Description : Directed bench for multi_key_debouncer (default, repeat, active-low).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_multi_key_debouncer;

    logic sys_clk;
    logic sys_rst_n;
    int   checks;
    int   errors;

    multi_key_debouncer_if #(.N_KEYS(3), .KEY_W(2)) bus0 ();
    multi_key_debouncer_if #(.N_KEYS(3), .KEY_W(2)) bus1 ();
    multi_key_debouncer_if #(.N_KEYS(3), .KEY_W(2)) bus2 ();

    multi_key_debouncer #(.REPEAT_EN(0), .ACTIVE_HIGH(1)) u_dut_def (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus0)
    );

    multi_key_debouncer #(.REPEAT_EN(1), .ACTIVE_HIGH(1)) u_dut_rpt (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus1)
    );

    multi_key_debouncer #(.REPEAT_EN(0), .ACTIVE_HIGH(0)) u_dut_low (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus2)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Same logical pattern to the active-high and active-low instances.
    task automatic set_keys(input logic [2:0] p);
        bus0.key_raw = p;
        bus2.key_raw = ~p;
    endtask

    task automatic test_reset();
        sys_rst_n    = 1'b0;
        set_keys(3'b000);
        bus1.key_raw = 3'b000;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if ({bus0.key_level, bus0.key_press, bus0.key_release, bus0.key_code,
             bus0.key_valid, bus0.any_pressed} !== 13'd0) begin
            errors++;
            $display("FAIL reset_def got lvl=%b prs=%b rel=%b code=%0d vld=%b any=%b exp all 0",
                     bus0.key_level, bus0.key_press, bus0.key_release, bus0.key_code,
                     bus0.key_valid, bus0.any_pressed);
        end
        checks++;
        if ({bus1.key_level, bus1.key_press, bus1.key_release, bus1.key_code,
             bus1.key_valid, bus1.any_pressed} !== 13'd0) begin
            errors++;
            $display("FAIL reset_rpt got lvl=%b prs=%b code=%0d exp all 0",
                     bus1.key_level, bus1.key_press, bus1.key_code);
        end
        checks++;
        if ({bus2.key_level, bus2.key_press, bus2.key_release, bus2.key_code,
             bus2.key_valid, bus2.any_pressed} !== 13'd0) begin
            errors++;
            $display("FAIL reset_low got lvl=%b prs=%b code=%0d exp all 0",
                     bus2.key_level, bus2.key_press, bus2.key_code);
        end
        sys_rst_n = 1'b1;
    endtask

    task automatic test_single_press();
        logic [2:0] e_press, e_rel, e_lvl;
        set_keys(3'b001);
        for (int i = 0; i < 26; i++) begin
            step();
            if (i == 11) set_keys(3'b000);
            e_press = (i == 6) ? 3'b001 : 3'b000;
            e_rel   = (i == 18) ? 3'b001 : 3'b000;
            e_lvl   = (i >= 6 && i < 18) ? 3'b001 : 3'b000;
            checks++;
            if (bus0.key_press !== e_press || bus0.key_release !== e_rel ||
                bus0.key_level !== e_lvl) begin
                errors++;
                $display("FAIL single_press cyc %0d got prs=%b rel=%b lvl=%b exp prs=%b rel=%b lvl=%b",
                         i, bus0.key_press, bus0.key_release, bus0.key_level, e_press, e_rel, e_lvl);
            end
            checks++;
            if (bus0.key_valid !== (i == 6) || bus0.key_code !== 2'd0 ||
                bus0.any_pressed !== (e_lvl != 3'b000)) begin
                errors++;
                $display("FAIL single_enc cyc %0d got vld=%b code=%0d any=%b exp vld=%b code=0 any=%b",
                         i, bus0.key_valid, bus0.key_code, bus0.any_pressed, (i == 6), (e_lvl != 3'b000));
            end
            checks++;
            if (bus2.key_press !== e_press || bus2.key_release !== e_rel ||
                bus2.key_level !== e_lvl) begin
                errors++;
                $display("FAIL single_low cyc %0d got prs=%b rel=%b lvl=%b exp prs=%b rel=%b lvl=%b",
                         i, bus2.key_press, bus2.key_release, bus2.key_level, e_press, e_rel, e_lvl);
            end
        end
    endtask

    task automatic test_bounce();
        logic [2:0] seq [20];
        seq = '{3'b001, 3'b100, 3'b100, 3'b000, 3'b001, 3'b001, 3'b100, 3'b000,
                3'b001, 3'b100, 3'b000, 3'b000, 3'b001, 3'b001, 3'b100, 3'b100,
                3'b000, 3'b001, 3'b100, 3'b000};
        for (int i = 0; i < 36; i++) begin
            if (i < 20)      set_keys(seq[i]);
            else if (i < 23) set_keys(3'b010);
            else             set_keys(3'b000);
            step();
            checks++;
            if (bus0.key_press !== 3'b000 || bus0.key_release !== 3'b000 ||
                bus0.key_level !== 3'b000 || bus0.key_valid !== 1'b0) begin
                errors++;
                $display("FAIL bounce cyc %0d got prs=%b rel=%b lvl=%b vld=%b exp all 0",
                         i, bus0.key_press, bus0.key_release, bus0.key_level, bus0.key_valid);
            end
        end
    endtask

    task automatic test_two_keys();
        logic [2:0] e_press, e_rel, e_lvl;
        logic [1:0] e_code;
        set_keys(3'b110);
        for (int i = 0; i < 22; i++) begin
            step();
            if (i == 9) set_keys(3'b000);
            e_press = (i == 6) ? 3'b110 : 3'b000;
            e_rel   = (i == 16) ? 3'b110 : 3'b000;
            e_lvl   = (i >= 6 && i < 16) ? 3'b110 : 3'b000;
            e_code  = (i >= 6) ? 2'd1 : 2'd0;
            checks++;
            if (bus0.key_press !== e_press || bus0.key_release !== e_rel ||
                bus0.key_level !== e_lvl) begin
                errors++;
                $display("FAIL two_keys cyc %0d got prs=%b rel=%b lvl=%b exp prs=%b rel=%b lvl=%b",
                         i, bus0.key_press, bus0.key_release, bus0.key_level, e_press, e_rel, e_lvl);
            end
            checks++;
            if (bus0.key_valid !== (i == 6) || bus0.key_code !== e_code ||
                bus0.any_pressed !== (e_lvl != 3'b000)) begin
                errors++;
                $display("FAIL two_enc cyc %0d got vld=%b code=%0d any=%b exp vld=%b code=%0d any=%b",
                         i, bus0.key_valid, bus0.key_code, bus0.any_pressed, (i == 6), e_code,
                         (e_lvl != 3'b000));
            end
        end
    endtask

    task automatic test_repeat();
        logic [2:0] e_press;
        bus1.key_raw = 3'b001;
        for (int i = 0; i < 36; i++) begin
            step();
            if (i == 24) bus1.key_raw = 3'b000;
            e_press = (i == 6 || i == 14 || i == 17 || i == 20 || i == 23 || i == 26)
                      ? 3'b001 : 3'b000;
            checks++;
            if (bus1.key_press !== e_press || bus1.key_valid !== (e_press != 3'b000)) begin
                errors++;
                $display("FAIL repeat cyc %0d got prs=%b vld=%b exp prs=%b vld=%b",
                         i, bus1.key_press, bus1.key_valid, e_press, (e_press != 3'b000));
            end
            checks++;
            if (bus1.key_release !== ((i == 31) ? 3'b001 : 3'b000)) begin
                errors++;
                $display("FAIL repeat_rel cyc %0d got rel=%b exp rel=%b",
                         i, bus1.key_release, ((i == 31) ? 3'b001 : 3'b000));
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [2:0] e_press;
        logic [1:0] e_code;
        set_keys(3'b010);
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (bus0.key_level !== 3'b010 || bus2.key_level !== 3'b010) begin
            errors++;
            $display("FAIL hold_before_rst got def=%b low=%b exp 010", bus0.key_level, bus2.key_level);
        end
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({bus0.key_level, bus0.key_code, bus0.any_pressed} !== 6'd0 ||
            {bus2.key_level, bus2.key_code, bus2.any_pressed} !== 6'd0) begin
            errors++;
            $display("FAIL async_rst got def lvl=%b code=%0d low lvl=%b code=%0d exp 0",
                     bus0.key_level, bus0.key_code, bus2.key_level, bus2.key_code);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus0.key_release !== 3'b000 || bus2.key_release !== 3'b000 ||
                bus0.key_press !== 3'b000 || bus2.key_press !== 3'b000) begin
                errors++;
                $display("FAIL rst_pulse cyc %0d got def rel=%b prs=%b low rel=%b prs=%b exp 0",
                         i, bus0.key_release, bus0.key_press, bus2.key_release, bus2.key_press);
            end
        end
        sys_rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            e_press = (i == 6) ? 3'b010 : 3'b000;
            e_code  = (i >= 6) ? 2'd1 : 2'd0;
            checks++;
            if (bus0.key_press !== e_press || bus0.key_code !== e_code ||
                bus0.key_release !== 3'b000) begin
                errors++;
                $display("FAIL repress_def cyc %0d got prs=%b code=%0d rel=%b exp prs=%b code=%0d rel=000",
                         i, bus0.key_press, bus0.key_code, bus0.key_release, e_press, e_code);
            end
            checks++;
            if (bus2.key_press !== e_press || bus2.key_code !== e_code ||
                bus2.key_release !== 3'b000) begin
                errors++;
                $display("FAIL repress_low cyc %0d got prs=%b code=%0d rel=%b exp prs=%b code=%0d rel=000",
                         i, bus2.key_press, bus2.key_code, bus2.key_release, e_press, e_code);
            end
        end
        set_keys(3'b000);
        for (int i = 0; i < 12; i++) step();
        checks++;
        if (bus0.key_level !== 3'b000 || bus2.key_level !== 3'b000) begin
            errors++;
            $display("FAIL final_release got def=%b low=%b exp 000", bus0.key_level, bus2.key_level);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        sys_rst_n = 1'b0;
        set_keys(3'b000);
        bus1.key_raw = 3'b000;
        test_reset();
        test_single_press();
        test_bounce();
        test_two_keys();
        test_repeat();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
